rns_floor_q: RTL and testbench

- Downstream consumer of the fast base-conversion stage. Completes the BEHZ exact-floor step: given x over the extended basis q∪B∪Ba and c = FastBConv(x mod q) over the same basis, it outputs floor(x/q) over B∪Ba.
- Per output lane j: y_j = ((x_j − c_j) mod m_j) · (q⁻¹ mod m_j) mod m_j.
- One shared modular multiplier is time-multiplexed across lanes.

---
 rtl/rns_floor_q_pkg.sv | 28 ++
 rtl/rns_modsub_mul.sv | 39 +++
 rtl/rns_floor_q.sv | 173 +++++++++++++++++
 tb/tb_rns_floor_q.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rns_floor_q_pkg.sv
// rtl/rns_floor_q_pkg.sv - residue types, tiny default bases and FSM states for the BEHZ floor stage
package rns_floor_q_pkg;

    localparam int RES_W  = 32;
    localparam int WIDE_W = 2 * RES_W;

    typedef logic [RES_W-1:0]  rns_residue_t;
    typedef logic [WIDE_W-1:0] wide_rns_residue_t;

    localparam int Q_BASIS_LEN    = 2;
    localparam int QBBA_BASIS_LEN = 4;
    localparam int BBA_BASIS_LEN  = QBBA_BASIS_LEN - Q_BASIS_LEN;

    // Element [0] is the first q modulus; q = 7*11 = 77.
    localparam rns_residue_t [QBBA_BASIS_LEN-1:0] QBBA_BASIS =
        {32'd17, 32'd13, 32'd11, 32'd7};

    // q^-1 mod 13 = 12, q^-1 mod 17 = 2
    localparam rns_residue_t [BBA_BASIS_LEN-1:0] QINV_MOD_BBA =
        {32'd2, 32'd12};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_DONE
    } floor_state_t;

endpackage

// File: rtl/rns_modsub_mul.sv
// rtl/rns_modsub_mul.sv - registered lane datapath y = ((x - c) mod m) * qinv mod m
module rns_modsub_mul
    import rns_floor_q_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  rns_residue_t i_x,
    input  rns_residue_t i_c,
    input  rns_residue_t i_qinv,
    input  rns_residue_t i_m,
    output rns_residue_t o_y
);

    logic [RES_W:0]    w_d;
    wide_rns_residue_t w_p;
    rns_residue_t      r_y;

    // One extra bit keeps x + m - c exact even for out-of-range residues.
    always_comb begin
        if ({1'b0, i_x} >= {1'b0, i_c}) begin
            w_d = {1'b0, i_x} - {1'b0, i_c};
        end else begin
            w_d = {1'b0, i_x} + {1'b0, i_m} - {1'b0, i_c};
        end
        w_p = WIDE_W'(w_d) * WIDE_W'(i_qinv);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_y <= '0;
        end else if (i_en) begin
            r_y <= rns_residue_t'(w_p % WIDE_W'(i_m));
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/rns_floor_q.sv
// rtl/rns_floor_q.sv - BEHZ exact floor(x/q) over B u Ba with one shared lane multiplier; option RNS_FLOOR_QCHECK_EN
module rns_floor_q
    import rns_floor_q_pkg::*;
#(
    parameter int                         Q_LEN     = Q_BASIS_LEN,
    parameter int                         EXT_LEN   = QBBA_BASIS_LEN,
    parameter int                         OUT_LEN   = EXT_LEN - Q_LEN,
    parameter rns_residue_t [EXT_LEN-1:0] EXT_BASIS = QBBA_BASIS,
    parameter rns_residue_t [OUT_LEN-1:0] QINV_LUT  = QINV_MOD_BBA
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  rns_residue_t [EXT_LEN-1:0]   x_RNSint,
    input  rns_residue_t [EXT_LEN-1:0]   conv_RNSint,
    output logic                         out_valid,
    output rns_residue_t [OUT_LEN-1:0]   output_RNSint
`ifdef RNS_FLOOR_QCHECK_EN
    ,
    output logic                         qcheck_err
`endif
);

`ifdef RNS_FLOOR_QCHECK_EN
    localparam int PRE_LEN = Q_LEN;
`else
    localparam int PRE_LEN = 0;
`endif
    localparam int LAST_CNT = PRE_LEN + OUT_LEN - 1;
    localparam int CNT_W    = $clog2(PRE_LEN + OUT_LEN + 1);
    localparam int LANE_W   = $clog2(OUT_LEN + 1);

    floor_state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    rns_residue_t [OUT_LEN-1:0] r_x_bba, r_c_bba, r_out;
    logic                       w_accept, w_in_lanes, w_issue;
    logic [LANE_W-1:0]          w_lane;
    rns_residue_t               w_op_x, w_op_c, w_op_qinv, w_op_m, w_y;

    assign in_ready      = (r_state == ST_IDLE);
    assign w_accept      = in_ready && in_valid;
    assign out_valid     = (r_state == ST_DONE);
    assign output_RNSint = r_out;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_COMPUTE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_COMPUTE: begin
                if (r_cnt == CNT_W'(LAST_CNT)) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Lane 0 is issued straight from the ports on the accept edge; each lane
    // cycle then retires lane j from the multiplier and issues lane j+1.
    always_comb begin
        w_issue   = w_accept;
        w_op_x    = x_RNSint[Q_LEN];
        w_op_c    = conv_RNSint[Q_LEN];
        w_op_qinv = QINV_LUT[0];
        w_op_m    = EXT_BASIS[Q_LEN];
        if (r_state == ST_COMPUTE && w_in_lanes) begin
            for (int j = 1; j < OUT_LEN; j++) begin
                if (w_lane == LANE_W'(j - 1)) begin
                    w_issue   = 1'b1;
                    w_op_x    = r_x_bba[j];
                    w_op_c    = r_c_bba[j];
                    w_op_qinv = QINV_LUT[j];
                    w_op_m    = EXT_BASIS[Q_LEN + j];
                end
            end
        end
    end

    rns_modsub_mul u_modsub_mul (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_issue),
        .i_x    (w_op_x),
        .i_c    (w_op_c),
        .i_qinv (w_op_qinv),
        .i_m    (w_op_m),
        .o_y    (w_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_x_bba <= '0;
            r_c_bba <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_x_bba <= x_RNSint[EXT_LEN-1:Q_LEN];
                r_c_bba <= conv_RNSint[EXT_LEN-1:Q_LEN];
            end
            if (r_state == ST_COMPUTE && w_in_lanes) begin
                for (int j = 0; j < OUT_LEN; j++) begin
                    if (w_lane == LANE_W'(j)) begin
                        r_out[j] <= w_y;
                    end
                end
            end
        end
    end

`ifdef RNS_FLOOR_QCHECK_EN
    rns_residue_t [Q_LEN-1:0] r_x_q, r_c_q;
    logic                     r_qerr;
    logic                     w_qmis;

    assign w_in_lanes = (r_cnt >= CNT_W'(Q_LEN));
    assign w_lane     = LANE_W'(r_cnt - CNT_W'(Q_LEN));
    assign qcheck_err = out_valid && r_qerr;

    // The leading COMPUTE cycles compare one q position each: a consistent
    // fastBConv must reproduce x exactly on the q part.
    always_comb begin
        w_qmis = 1'b0;
        if (r_state == ST_COMPUTE && !w_in_lanes) begin
            for (int i = 0; i < Q_LEN; i++) begin
                if (r_cnt == CNT_W'(i) && r_x_q[i] != r_c_q[i]) begin
                    w_qmis = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_q  <= '0;
            r_c_q  <= '0;
            r_qerr <= 1'b0;
        end else if (w_accept) begin
            r_x_q  <= x_RNSint[Q_LEN-1:0];
            r_c_q  <= conv_RNSint[Q_LEN-1:0];
            r_qerr <= 1'b0;
        end else if (w_qmis) begin
            r_qerr <= 1'b1;
        end
    end
`else
    logic w_unused_q;

    assign w_in_lanes = 1'b1;
    assign w_lane     = LANE_W'(r_cnt);
    assign w_unused_q = ^{x_RNSint[Q_LEN-1:0], conv_RNSint[Q_LEN-1:0]};
`endif

endmodule

// File: tb/tb_rns_floor_q.sv
// tb/tb_rns_floor_q.sv - directed and small-random checks of rns_floor_q on q={7,11}, B={13,17}
module tb_rns_floor_q;
    import rns_floor_q_pkg::*;

`ifdef RNS_FLOOR_QCHECK_EN
    localparam int LAT = Q_BASIS_LEN + BBA_BASIS_LEN + 1;
`else
    localparam int LAT = BBA_BASIS_LEN + 1;
`endif
    localparam int GAP = LAT + 1;

    logic                                clk = 1'b0;
    logic                                reset;
    logic                                in_valid;
    logic                                in_ready;
    rns_residue_t [QBBA_BASIS_LEN-1:0]   x_RNSint;
    rns_residue_t [QBBA_BASIS_LEN-1:0]   conv_RNSint;
    logic                                out_valid;
    rns_residue_t [BBA_BASIS_LEN-1:0]    output_RNSint;
`ifdef RNS_FLOOR_QCHECK_EN
    logic                                qcheck_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rns_floor_q #(
        .Q_LEN     (Q_BASIS_LEN),
        .EXT_LEN   (QBBA_BASIS_LEN),
        .OUT_LEN   (BBA_BASIS_LEN),
        .EXT_BASIS (QBBA_BASIS),
        .QINV_LUT  (QINV_MOD_BBA)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .x_RNSint      (x_RNSint),
        .conv_RNSint   (conv_RNSint),
        .out_valid     (out_valid),
        .output_RNSint (output_RNSint)
`ifdef RNS_FLOOR_QCHECK_EN
        ,
        .qcheck_err    (qcheck_err)
`endif
    );

    typedef struct {
        string                    name;
        rns_residue_t [3:0]       x;
        rns_residue_t [3:0]       c;
        rns_residue_t [1:0]       y;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic rns_residue_t [3:0] mk4(input int a0, input int a1, input int a2, input int a3);
        rns_residue_t [3:0] r;
        r[0] = rns_residue_t'(a0);
        r[1] = rns_residue_t'(a1);
        r[2] = rns_residue_t'(a2);
        r[3] = rns_residue_t'(a3);
        return r;
    endfunction

    function automatic rns_residue_t [1:0] mk2(input int a0, input int a1);
        rns_residue_t [1:0] r;
        r[0] = rns_residue_t'(a0);
        r[1] = rns_residue_t'(a1);
        return r;
    endfunction

    task automatic run_bundle(input string name, input rns_residue_t [3:0] x,
                              input rns_residue_t [3:0] c, input rns_residue_t [1:0] exp_y);
        int lat;
        bit seen;
        @(negedge clk);
        chk({name, " in_ready"}, in_ready, 1);
        x_RNSint    = x;
        conv_RNSint = c;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
        x_RNSint    = {4{32'hDEADBEEF}};
        conv_RNSint = {4{32'h12345678}};
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({name, " latency"}, seen ? lat : -1, LAT);
        if (seen) begin
            chk({name, " lane0"}, output_RNSint[0], exp_y[0]);
            chk({name, " lane1"}, output_RNSint[1], exp_y[1]);
`ifdef RNS_FLOOR_QCHECK_EN
            chk({name, " qcheck_err"}, qcheck_err, (x[0] != c[0]) || (x[1] != c[1]));
`endif
            @(negedge clk);
            chk({name, " strobe one cycle"}, out_valid, 0);
        end
    endtask

    initial begin
        int acc_cyc[2];
        int n_acc, n_out, busy, n_ov, n_lo;
        rns_residue_t [1:0] exp_b2b[2];

        vecs[0] = '{"x1000",  mk4(6, 10, 12, 14), mk4(6, 10, 11, 8),  mk2(12, 12)};
        vecs[1] = '{"x87",    mk4(3, 10, 9, 2),   mk4(3, 10, 10, 10), mk2(1, 1)};
        vecs[2] = '{"x388",   mk4(3, 3, 11, 14),  mk4(3, 3, 3, 3),    mk2(5, 5)};
        vecs[3] = '{"x0",     mk4(0, 0, 0, 0),    mk4(0, 0, 0, 0),    mk2(0, 0)};
        vecs[4] = '{"x76",    mk4(6, 10, 11, 8),  mk4(6, 10, 11, 8),  mk2(0, 0)};
        vecs[5] = '{"x77",    mk4(0, 0, 12, 9),   mk4(0, 0, 0, 0),    mk2(1, 1)};
        vecs[6] = '{"x17016", mk4(6, 10, 12, 16), mk4(6, 10, 11, 8),  mk2(12, 16)};
        vecs[7] = '{"oob",    mk4(0, 0, 20, 40),  mk4(0, 0, 3, 3),    mk2(9, 6)};
        vecs[8] = '{"qbad",   mk4(6, 10, 12, 14), mk4(6, 9, 11, 8),   mk2(12, 12)};

        reset       = 1'b1;
        in_valid    = 1'b0;
        x_RNSint    = '0;
        conv_RNSint = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset output", output_RNSint, 0);

        foreach (vecs[i]) run_bundle(vecs[i].name, vecs[i].x, vecs[i].c, vecs[i].y);

        for (int t = 0; t < 12; t++) begin
            longint unsigned xv;
            rns_residue_t [3:0] rx, rc;
            rns_residue_t [1:0] ry;
            xv = longint'($urandom);
            for (int k = 0; k < 4; k++) begin
                rx[k] = rns_residue_t'(xv % QBBA_BASIS[k]);
                rc[k] = rns_residue_t'((xv % 77) % QBBA_BASIS[k]);
            end
            ry[0] = rns_residue_t'((xv / 77) % 13);
            ry[1] = rns_residue_t'((xv / 77) % 17);
            run_bundle($sformatf("rand%0d", t), rx, rc, ry);
        end

        // in_valid held high across two bundles
        exp_b2b[0] = vecs[0].y;
        exp_b2b[1] = vecs[1].y;
        n_acc = 0;
        n_out = 0;
        busy  = 0;
        @(negedge clk);
        x_RNSint    = vecs[0].x;
        conv_RNSint = vecs[0].c;
        in_valid    = 1'b1;
        for (int k = 0; k < 4 * GAP; k++) begin
            if (out_valid) begin
                if (n_out < 2) begin
                    chk($sformatf("b2b out%0d lane0", n_out), output_RNSint[0], exp_b2b[n_out][0]);
                    chk($sformatf("b2b out%0d lane1", n_out), output_RNSint[1], exp_b2b[n_out][1]);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                if (n_acc < 2) acc_cyc[n_acc] = k;
                n_acc++;
            end else if (in_valid) begin
                busy++;
            end
            @(negedge clk);
            if (n_acc == 1) begin
                x_RNSint    = vecs[1].x;
                conv_RNSint = vecs[1].c;
            end
            if (n_acc >= 2) in_valid = 1'b0;
        end
        chk("b2b accepts", n_acc, 2);
        chk("b2b outputs", n_out, 2);
        chk("b2b accept gap", (n_acc >= 2) ? acc_cyc[1] - acc_cyc[0] : -1, GAP);
        chk("b2b busy cycles", busy, GAP - 1);

        // reset during lane 1 aborts the bundle
        @(negedge clk);
        x_RNSint    = vecs[0].x;
        conv_RNSint = vecs[0].c;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT - 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_ov = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) n_ov++;
            @(negedge clk);
        end
        chk("abort no out_valid", n_ov, 0);
        chk("abort output cleared", output_RNSint, 0);
        chk("abort in_ready", in_ready, 1);
        run_bundle("after abort x388", vecs[2].x, vecs[2].c, vecs[2].y);

        // reset together with in_valid: nothing accepted
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        n_ov = 0;
        n_lo = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) n_ov++;
            if (!in_ready) n_lo++;
            @(negedge clk);
        end
        chk("reset+valid no out_valid", n_ov, 0);
        chk("reset+valid stays idle", n_lo, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
